// File: rtl/approx_mult_pipe.sv
// Two-stage pipelined unsigned approximate multiplier with valid/ready handshake.
// Define APPROX_ERR_STAT_EN to add error statistics ports (stat_clr, stat_cnt, stat_err).
module approx_mult_pipe #(
  parameter int unsigned W = 8,
  parameter int unsigned L = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_x,
  input  logic [W-1:0]   in_y,
  input  logic           in_exact,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_z,
  output logic           out_exact
`ifdef APPROX_ERR_STAT_EN
  ,
  input  logic           stat_clr,
  output logic [31:0]    stat_cnt,
  output logic [31:0]    stat_err
`endif
);

  localparam int unsigned ZW = 2 * W;
  localparam logic [ZW-1:0] HiMask = {{W{1'b1}}, {W{1'b0}}};

  logic          s1_valid_q, s1_valid_d;
  logic [ZW-1:0] s1_hi_q, s1_hi_d;
  logic [ZW-1:0] s1_lo_q, s1_lo_d;
  logic          s1_exact_q, s1_exact_d;
  logic          s2_valid_q, s2_valid_d;
  logic [ZW-1:0] s2_z_q, s2_z_d;
  logic          s2_exact_q, s2_exact_d;

  logic          s1_adv, s1_load, s2_load;
  logic [W-1:0]  x_hi, x_lo, x_sh;
  logic [ZW-1:0] y_ext, hi_prod, lo_exact, lo_approx, row_e, row_o;

  // Low rows: truncated below column W, rows paired 2k/2k+1 and merged with OR.
  always_comb begin
    y_ext = ZW'(in_y);
    x_hi  = in_x >> L;
    for (int i = 0; i < int'(W); i++) begin
      x_lo[i] = (i < int'(L)) ? in_x[i] : 1'b0;
    end
    hi_prod   = (y_ext * ZW'(x_hi)) << L;
    lo_exact  = y_ext * ZW'(x_lo);
    lo_approx = '0;
    x_sh      = '0;
    row_e     = '0;
    row_o     = '0;
    for (int k = 0; k < int'(L / 2); k++) begin
      x_sh      = in_x >> (2 * k);
      row_e     = x_sh[0] ? (y_ext << (2 * k)) : '0;
      row_o     = x_sh[1] ? (y_ext << (2 * k + 1)) : '0;
      lo_approx = lo_approx + ((row_e | row_o) & HiMask);
    end
  end

  always_comb begin
    s1_adv   = !s2_valid_q | out_ready;
    in_ready = !s1_valid_q | s1_adv;
    s1_load  = in_valid & in_ready;
    s2_load  = s1_valid_q & s1_adv;

    s1_valid_d = s1_load | (s1_valid_q & !s1_adv);
    s1_hi_d    = s1_load ? hi_prod : s1_hi_q;
    s1_lo_d    = s1_load ? (in_exact ? lo_exact : lo_approx) : s1_lo_q;
    s1_exact_d = s1_load ? in_exact : s1_exact_q;

    s2_valid_d = s2_load | (s2_valid_q & !out_ready);
    s2_z_d     = s2_load ? (s1_hi_q + s1_lo_q) : s2_z_q;
    s2_exact_d = s2_load ? s1_exact_q : s2_exact_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_hi_q    <= '0;
      s1_lo_q    <= '0;
      s1_exact_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_z_q     <= '0;
      s2_exact_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_hi_q    <= s1_hi_d;
      s1_lo_q    <= s1_lo_d;
      s1_exact_q <= s1_exact_d;
      s2_valid_q <= s2_valid_d;
      s2_z_q     <= s2_z_d;
      s2_exact_q <= s2_exact_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_z     = s2_z_q;
  assign out_exact = s2_exact_q;

`ifdef APPROX_ERR_STAT_EN
  // The exact low-row sum travels alongside so S2 can hold the exact product.
  logic [ZW-1:0] s1_lo_ex_q, s1_lo_ex_d;
  logic [ZW-1:0] s2_zx_q, s2_zx_d;
  logic [31:0]   stat_cnt_q, stat_cnt_d, stat_err_q, stat_err_d;
  logic [ZW-1:0] err_diff;
  logic [64:0]   err_sum;
  logic          stat_upd;

  always_comb begin
    s1_lo_ex_d = s1_load ? lo_exact : s1_lo_ex_q;
    s2_zx_d    = s2_load ? (s1_hi_q + s1_lo_ex_q) : s2_zx_q;
    stat_upd   = s2_valid_q & out_ready & !s2_exact_q;
    err_diff   = s2_zx_q - s2_z_q;
    err_sum    = 65'(stat_err_q) + 65'(err_diff);
    stat_cnt_d = stat_cnt_q;
    stat_err_d = stat_err_q;
    if (stat_clr) begin
      stat_cnt_d = '0;
      stat_err_d = '0;
    end else if (stat_upd) begin
      stat_cnt_d = stat_cnt_q + 32'd1;
      stat_err_d = (err_sum > 65'h0_FFFF_FFFF) ? 32'hFFFF_FFFF : err_sum[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_lo_ex_q <= '0;
      s2_zx_q    <= '0;
      stat_cnt_q <= '0;
      stat_err_q <= '0;
    end else begin
      s1_lo_ex_q <= s1_lo_ex_d;
      s2_zx_q    <= s2_zx_d;
      stat_cnt_q <= stat_cnt_d;
      stat_err_q <= stat_err_d;
    end
  end

  assign stat_cnt = stat_cnt_q;
  assign stat_err = stat_err_q;
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Directed self-checking bench for approx_mult_pipe (W=8, L=6) with a result scoreboard.
module tb_approx_mult_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_x;
  logic [7:0]  in_y;
  logic        in_exact;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_z;
  logic        out_exact;
`ifdef APPROX_ERR_STAT_EN
  logic        stat_clr;
  logic [31:0] stat_cnt;
  logic [31:0] stat_err;
`endif

  approx_mult_pipe #(
    .W(8),
    .L(6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_exact  (in_exact),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .out_exact (out_exact)
`ifdef APPROX_ERR_STAT_EN
    ,
    .stat_clr  (stat_clr),
    .stat_cnt  (stat_cnt),
    .stat_err  (stat_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] z;
    logic        ex;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  logic lat_chk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard: every output transfer must match the oldest accepted beat.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check_eq("unexpected_out", 64'(out_valid), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check_eq("out_z", 64'(out_z), 64'(e.z));
        check_eq("out_exact", 64'(out_exact), 64'(e.ex));
        if (lat_chk) check_eq("latency", 64'(cyc - e.cyc), 64'd2);
      end
    end
  end

  // Call and return just after a rising edge.
  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic ex,
                      input logic [15:0] expz);
    exp_t e;
    in_x     = x;
    in_y     = y;
    in_exact = ex;
    in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        e.z   = expz;
        e.ex  = ex;
        e.cyc = cyc;
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    check_eq("send_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && q.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    check_eq("drain", 64'(q.size()), 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    in_exact  = 1'b0;
    out_ready = 1'b1;
    lat_chk   = 1'b1;
`ifdef APPROX_ERR_STAT_EN
    stat_clr  = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_z", 64'(out_z), 64'd0);
    check_eq("rst_out_exact", 64'(out_exact), 64'd0);
    @(posedge clk);
    #1;

    // Single directed beats
    send(8'd255, 8'd255, 1'b0, 16'd58944); drain();
    send(8'd255, 8'd255, 1'b1, 16'd65025); drain();
    send(8'd3,   8'd128, 1'b0, 16'd256);   drain();
    send(8'd3,   8'd128, 1'b1, 16'd384);   drain();
    send(8'd64,  8'd200, 1'b0, 16'd12800); drain();
    send(8'd64,  8'd200, 1'b1, 16'd12800); drain();
    send(8'd0,   8'd255, 1'b0, 16'd0);     drain();
    send(8'd0,   8'd255, 1'b1, 16'd0);     drain();
    send(8'd255, 8'd0,   1'b0, 16'd0);     drain();

`ifdef APPROX_ERR_STAT_EN
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    send(8'd3, 8'd128, 1'b0, 16'd256); drain();
    check_eq("stat_cnt_one", 64'(stat_cnt), 64'd1);
    check_eq("stat_err_128", 64'(stat_err), 64'd128);
    send(8'd3, 8'd128, 1'b1, 16'd384); drain();
    check_eq("stat_cnt_exact_skip", 64'(stat_cnt), 64'd1);
    check_eq("stat_err_exact_skip", 64'(stat_err), 64'd128);
    // Clear lands on the same edge as the output transfer of an approximate beat
    send(8'd3, 8'd128, 1'b0, 16'd256);
    @(posedge clk);
    #1;
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    check_eq("stat_clr_cnt", 64'(stat_cnt), 64'd0);
    check_eq("stat_clr_err", 64'(stat_err), 64'd0);
    drain();
`endif

    // Back-to-back beats, alternating modes
    send(8'd255, 8'd255, 1'b0, 16'd58944);
    send(8'd3,   8'd128, 1'b1, 16'd384);
    send(8'd64,  8'd200, 1'b0, 16'd12800);
    send(8'd3,   8'd128, 1'b0, 16'd256);
    drain();

    // Output stall with a continuous input stream
    lat_chk   = 1'b0;
    out_ready = 1'b0;
    fork
      begin
        send(8'd255, 8'd255, 1'b0, 16'd58944);
        send(8'd255, 8'd255, 1'b1, 16'd65025);
        send(8'd3,   8'd128, 1'b0, 16'd256);
        send(8'd64,  8'd200, 1'b1, 16'd12800);
      end
      begin
        for (int n = 1; n <= 5; n++) begin
          @(negedge clk);
          if (n <= 2) begin
            check_eq("stall_in_ready_hi", 64'(in_ready), 64'd1);
          end else begin
            check_eq("stall_in_ready_lo", 64'(in_ready), 64'd0);
            check_eq("stall_out_valid", 64'(out_valid), 64'd1);
            check_eq("stall_out_z_held", 64'(out_z), 64'd58944);
            check_eq("stall_exact_held", 64'(out_exact), 64'd0);
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(8'd255, 8'd255, 1'b1, 16'd65025);
    send(8'd64,  8'd200, 1'b0, 16'd12800);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    out_ready = 1'b1;
    @(negedge clk);
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
    check_eq("midrst_out_z", 64'(out_z), 64'd0);
    repeat (6) @(posedge clk);
    #1;
    lat_chk = 1'b1;
    send(8'd3, 8'd128, 1'b1, 16'd384); drain();

    check_eq("leftover", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
